// File: rtl/a23_copro_initiator.sv
// Request/response initiator that turns single CP15 register reads and writes
// into MRC/MCR operations on the coprocessor interface, honouring the fetch stall.
module a23_copro_initiator #(
  parameter logic [3:0] COPRO_NUM = 4'd15,
  parameter logic [2:0] OPCODE1   = 3'd0,
  parameter logic [2:0] OPCODE2   = 3'd0,
  parameter logic [3:0] CRM       = 4'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fetch_stall,

  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [3:0]  i_req_crn,
  input  logic [31:0] i_req_wdata,

  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,

  output logic [1:0]  o_copro_operation,
  output logic [3:0]  o_copro_crn,
  output logic [31:0] o_copro_write_data,
  output logic [2:0]  o_copro_opcode1,
  output logic [2:0]  o_copro_opcode2,
  output logic [3:0]  o_copro_crm,
  output logic [3:0]  o_copro_num,
  input  logic [31:0] i_copro_read_data,

  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP,
    ERR
  } state_t;

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_MRC  = 2'd1;
  localparam logic [1:0] OP_MCR  = 2'd2;

  state_t      state_q, state_d;
  logic        write_q;
  logic [3:0]  crn_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        req_legal;

  assign accept = i_req_valid && o_req_ready;

  // Writable: crn 1..5. Readable: crn 0 and 2..7 (crn 1 is the write-only flush).
  always_comb begin
    if (i_req_write)
      req_legal = (i_req_crn >= 4'd1) && (i_req_crn <= 4'd5);
    else
      req_legal = (i_req_crn == 4'd0) ||
                  ((i_req_crn >= 4'd2) && (i_req_crn <= 4'd7));
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_legal ? ISSUE : ERR;
      ISSUE:   if (!i_fetch_stall) state_d = write_q ? RESP : CAPTURE;
      CAPTURE: state_d = RESP;
      ERR:     state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      crn_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q <= i_req_write;
            crn_q   <= i_req_crn;
            wdata_q <= i_req_wdata;
          end
        end
        ISSUE: begin
          if (!i_fetch_stall && write_q) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
          end
        end
        CAPTURE: begin
          // crn is still held, so the coprocessor's registered read data is for our register.
          rdata_q <= i_copro_read_data;
          err_q   <= 1'b0;
        end
        ERR: begin
          rdata_q <= 32'd0;
          err_q   <= 1'b1;
        end
        RESP: begin
          if (i_rsp_ready) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Decoded straight from the state register so reset removes the operation asynchronously.
  assign o_copro_operation  = (state_q == ISSUE) ? (write_q ? OP_MCR : OP_MRC) : OP_IDLE;
  assign o_copro_crn        = crn_q;
  assign o_copro_write_data = wdata_q;
  assign o_copro_opcode1    = OPCODE1;
  assign o_copro_opcode2    = OPCODE2;
  assign o_copro_crm        = CRM;
  assign o_copro_num        = COPRO_NUM;

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign o_busy      = (state_q != IDLE);

endmodule
